hps_pio_bank: RTL and testbench

//  Parametrised Avalon-MM slave on the HPS lightweight H2F bridge giving the HPS access to fabric I/O.

---
 rtl/hps_pio_bank_if.sv | 21 ++
 rtl/hps_pio_bank.sv | 144 ++++++++++++++
 tb/tb_hps_pio_bank.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/hps_pio_bank_if.sv
// Avalon-MM slave bus bundle for hps_pio_bank.
// Signals: avs_address (word address), avs_read / avs_write (strobes),
// avs_writedata (32-bit write data), avs_readdata (32-bit read data,
// valid one cycle after avs_read). No waitrequest, no byteenable.
interface hps_pio_bank_if;
  logic [2:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata,
    input  avs_readdata
  );

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata,
    output avs_readdata
  );
endinterface

// File: rtl/hps_pio_bank.sv
// HPS lightweight-bridge PIO bank: debounced inputs with edge capture and a
// maskable level interrupt, plus an output register with atomic set/clear.
// Ports:
//   clk      system clock
//   reset    asynchronous, active-high reset
//   avs      Avalon-MM slave bus (hps_pio_bank_if.slave)
//   pio_in   raw asynchronous input pins (N_IN)
//   pio_out  registered output pins (N_OUT)
//   irq      registered level interrupt, |(capture & mask)
// Register map (word address): 0 DATA_IN, 1 DATA_OUT, 2 SET, 3 CLR,
// 4 CAPTURE (W1C), 5 MASK, 6 EDGE_EN {fall[15:0], rise[15:0]}, 7 ID.
module hps_pio_bank #(
  parameter int              N_IN      = 10,
  parameter int              N_OUT     = 10,
  parameter int              DEBOUNCE  = 1000000,
  parameter logic [N_OUT-1:0] OUT_RESET = '0
) (
  input  logic             clk,
  input  logic             reset,
  hps_pio_bank_if.slave    avs,
  input  logic [N_IN-1:0]  pio_in,
  output logic [N_OUT-1:0] pio_out,
  output logic             irq
);
  localparam int             CW      = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE - 1);
  // EDGE_EN only has 16 bits per polarity, so channels beyond 15 have no
  // enable bits of their own.
  localparam int             NE      = (N_IN < 16) ? N_IN : 16;

  logic [N_IN-1:0]  sync1_q, sync2_q;
  logic [N_IN-1:0]  deb_q, deb_d;
  logic [CW-1:0]    cnt_q [N_IN];
  logic [CW-1:0]    cnt_d [N_IN];
  logic [N_IN-1:0]  capture_q, capture_d;
  logic [N_IN-1:0]  mask_q, mask_d;
  logic [NE-1:0]    rise_en_q, rise_en_d;
  logic [NE-1:0]    fall_en_q, fall_en_d;
  logic [N_OUT-1:0] out_q, out_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             irq_q;

  logic [N_IN-1:0]  rise_en_full, fall_en_full;
  logic [N_IN-1:0]  set_cap, cap_clr;
  logic [31:0]      wdata;
  logic             wr;
  logic [2:0]       addr;

  // Collects bus bits that no register consumes for narrow configurations.
  logic unused_wdata;
  assign unused_wdata = ^avs.avs_writedata;

  assign wdata = avs.avs_writedata;
  assign wr    = avs.avs_write;
  assign addr  = avs.avs_address;

  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < N_IN; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CNT_MAX) deb_d[i] = sync2_q[i];
        else                     cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end

    // Channels above 15 always capture rising edges and never falling ones.
    rise_en_full = '1;
    fall_en_full = '0;
    for (int i = 0; i < NE; i++) begin
      rise_en_full[i] = rise_en_q[i];
      fall_en_full[i] = fall_en_q[i];
    end

    set_cap = (deb_d & ~deb_q & rise_en_full) | (~deb_d & deb_q & fall_en_full);
    cap_clr = (wr && addr == 3'd4) ? wdata[N_IN-1:0] : '0;
    // A new edge wins over a simultaneous software clear.
    capture_d = (capture_q & ~cap_clr) | set_cap;

    out_d     = out_q;
    mask_d    = mask_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    if (wr) begin
      case (addr)
        3'd1: out_d = wdata[N_OUT-1:0];
        3'd2: out_d = out_q | wdata[N_OUT-1:0];
        3'd3: out_d = out_q & ~wdata[N_OUT-1:0];
        3'd5: mask_d = wdata[N_IN-1:0];
        3'd6: begin
          rise_en_d = wdata[NE-1:0];
          fall_en_d = wdata[NE+15:16];
        end
        default: ;
      endcase
    end

    // Read mux sees pre-write register values.
    rdata_d = rdata_q;
    if (avs.avs_read) begin
      case (addr)
        3'd0:    rdata_d = 32'(deb_q);
        3'd1:    rdata_d = 32'(out_q);
        3'd4:    rdata_d = 32'(capture_q);
        3'd5:    rdata_d = 32'(mask_q);
        3'd6:    rdata_d = {16'(fall_en_q), 16'(rise_en_q)};
        3'd7:    rdata_d = {8'(N_IN), 8'(N_OUT), 16'h0002};
        default: rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      deb_q     <= '0;
      for (int i = 0; i < N_IN; i++) cnt_q[i] <= '0;
      capture_q <= '0;
      mask_q    <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      out_q     <= OUT_RESET;
      rdata_q   <= '0;
      irq_q     <= 1'b0;
    end else begin
      sync1_q   <= pio_in;
      sync2_q   <= sync1_q;
      deb_q     <= deb_d;
      for (int i = 0; i < N_IN; i++) cnt_q[i] <= cnt_d[i];
      capture_q <= capture_d;
      mask_q    <= mask_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      out_q     <= out_d;
      rdata_q   <= rdata_d;
      irq_q     <= |(capture_q & mask_q);
    end
  end

  assign avs.avs_readdata = rdata_q;
  assign pio_out          = out_q;
  assign irq              = irq_q;
endmodule

// File: tb/tb_hps_pio_bank.sv
module tb_hps_pio_bank;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] pio_in = '0;
  logic [7:0] pio_out;
  logic       irq;
  int         total = 0;
  int         bad = 0;
  logic [31:0] rv;

  hps_pio_bank_if bus();

  hps_pio_bank #(
    .N_IN(4), .N_OUT(8), .DEBOUNCE(4), .OUT_RESET(8'hA5)
  ) dut (
    .clk(clk), .reset(reset), .avs(bus),
    .pio_in(pio_in), .pio_out(pio_out), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    bus.avs_address = a;
    bus.avs_read = 1'b1;
    tick();
    bus.avs_read = 1'b0;
    d = bus.avs_readdata;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    bus.avs_address = a;
    bus.avs_writedata = d;
    bus.avs_write = 1'b1;
    tick();
    bus.avs_write = 1'b0;
  endtask

  initial begin
    bus.avs_address = '0;
    bus.avs_read = 1'b0;
    bus.avs_write = 1'b0;
    bus.avs_writedata = '0;

    // 1: reset values, DATA_OUT and ID
    tick(); tick();
    reset = 1'b0;
    check("rst_pio_out", 32'(pio_out), 32'hA5);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_rdata", bus.avs_readdata, 32'h0);
    rd(3'd1, rv); check("rd_data_out", rv, 32'hA5);
    rd(3'd7, rv); check("rd_id", rv, 32'h0408_0002);
    rd(3'd4, rv); check("rst_capture", rv, 32'h0);

    // 2: write / set / clear on successive cycles
    wr(3'd1, 32'h0F); check("out_write", 32'(pio_out), 32'h0F);
    wr(3'd2, 32'h30); check("out_set", 32'(pio_out), 32'h3F);
    wr(3'd3, 32'h03); check("out_clr", 32'(pio_out), 32'h3C);
    rd(3'd2, rv); check("set_reads0", rv, 32'h0);
    rd(3'd3, rv); check("clr_reads0", rv, 32'h0);
    // simultaneous read and write returns the old value
    bus.avs_address = 3'd1; bus.avs_writedata = 32'h55;
    bus.avs_read = 1'b1; bus.avs_write = 1'b1;
    tick();
    bus.avs_read = 1'b0; bus.avs_write = 1'b0;
    check("rw_old_value", bus.avs_readdata, 32'h3C);
    check("rw_new_out", 32'(pio_out), 32'h55);
    wr(3'd5, 32'hFFFF_FFFF);
    rd(3'd5, rv); check("mask_high_bits", rv, 32'h0000_000F);
    wr(3'd5, 32'h0);

    // 3: ch0 held high, 3-cycle pulse on ch1; deb accepted on edge 6,
    // visible in continuously-read DATA_IN after edge 7
    pio_in = 4'b0011;
    bus.avs_address = 3'd0; bus.avs_read = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 3) pio_in[1] = 1'b0;
      if (k == 6) check("deb_before", bus.avs_readdata, 32'h0);
      if (k == 7) check("deb_after", bus.avs_readdata, 32'h1);
      if (k == 10) check("glitch_rejected", bus.avs_readdata, 32'h1);
    end
    bus.avs_read = 1'b0;
    rd(3'd4, rv); check("no_cap_disabled", rv, 32'h0);

    // 4: rising-edge capture, irq one cycle later, W1C
    wr(3'd6, 32'h0000_0001);
    wr(3'd5, 32'h0000_0001);
    pio_in[0] = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    rd(3'd4, rv); check("no_fall_cap", rv, 32'h0);
    pio_in[0] = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k == 6) check("irq_lag", 32'(irq), 32'h0);
      if (k == 7) check("irq_set", 32'(irq), 32'h1);
    end
    rd(3'd4, rv); check("cap_set", rv, 32'h1);
    wr(3'd4, 32'h1);
    tick();
    check("irq_cleared", 32'(irq), 32'h0);
    rd(3'd4, rv); check("cap_cleared", rv, 32'h0);

    // 5: fall capture, mask gating, then clear colliding with a new edge
    wr(3'd6, 32'h0001_0001);
    pio_in[0] = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    rd(3'd4, rv); check("fall_cap", rv, 32'h1);
    check("fall_irq", 32'(irq), 32'h1);
    wr(3'd5, 32'h0); tick();
    check("irq_masked", 32'(irq), 32'h0);
    wr(3'd5, 32'h1); tick();
    check("irq_unmasked", 32'(irq), 32'h1);
    pio_in[0] = 1'b1;
    for (int k = 1; k <= 5; k++) tick();
    wr(3'd4, 32'h1);
    check("collide_irq0", 32'(irq), 32'h1);
    tick();
    check("collide_irq1", 32'(irq), 32'h1);
    rd(3'd4, rv); check("collide_cap", rv, 32'h1);
    rd(3'd0, rv); check("collide_deb", rv, 32'h1);

    // 6: reset mid-debounce (ch1) and mid-read
    pio_in[1] = 1'b1;
    tick(); tick(); tick();
    bus.avs_address = 3'd1; bus.avs_read = 1'b1;
    #2 reset = 1'b1;
    #1;
    check("midrst_rdata", bus.avs_readdata, 32'h0);
    check("midrst_pio_out", 32'(pio_out), 32'hA5);
    check("midrst_irq", 32'(irq), 32'h0);
    bus.avs_read = 1'b0;
    tick(); tick();
    reset = 1'b0;
    bus.avs_address = 3'd0; bus.avs_read = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k == 6) check("post_rst_deb_before", bus.avs_readdata, 32'h0);
      if (k == 7) check("post_rst_deb_after", bus.avs_readdata, 32'h3);
    end
    bus.avs_read = 1'b0;
    rd(3'd4, rv); check("post_rst_cap", rv, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
